// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared types, widths and arbitration helpers for the LED blink scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int NREQ     = 4;
    localparam int PERIOD_W = 16;
    localparam int COUNT_W  = 8;
    localparam int IDX_W    = 2;

    // Round-robin: first requester after 'last', wrapping, with 'last' itself lowest.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] idx;
        rr_pick = last;
        // Walk from farthest to nearest so the nearest requesting index is kept.
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + k[IDX_W-1:0];
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // Fixed priority: lowest requesting index wins.
    function automatic logic [IDX_W-1:0] prio_pick(input logic [NREQ-1:0] r);
        prio_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (r[k]) prio_pick = IDX_W'(k);
        end
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: timebase prescaler counting 0..DIV-1; tick is high on the last count.
// clear restarts the count so every phase starts on a full tick interval.
module led_tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic sys_clk50m,
    input  logic sys_rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Prescaler: restart on clear, wrap after DIV-1.
    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst)                    cnt <= '0;
        else if (clear || cnt == LAST)  cnt <= '0;
        else                            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_blink_sched.sv
// led_blink_sched: grants one of four requesters, blinks the LED pair ON/OFF for the
// latched period and count, then enforces an idle GAP before the next grant.
// Macro LED_SCHED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module led_blink_sched
    import led_sched_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int GAP_MS  = 100
) (
    input  logic                     sys_clk50m,
    input  logic                     sys_rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*PERIOD_W-1:0] period_ms,
    input  logic [NREQ*COUNT_W-1:0]  blinks,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [1:0]               led
);
    // DIV must be at least 2 so a cleared prescaler never ticks immediately.
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int GAP_TICKS = (GAP_MS < 1) ? 1 : GAP_MS;
    localparam logic [PERIOD_W-1:0] GAP_LAST = PERIOD_W'(GAP_TICKS - 1);

    state_t               state, state_nxt;
    logic [PERIOD_W-1:0]  period_q, ph_cnt, ph_last, sel_period;
    logic [COUNT_W-1:0]   rem_q, sel_blinks;
    logic [NREQ-1:0]      gnt_q, done_q;
    logic [IDX_W-1:0]     sel_idx;
    logic                 tick, clear, ph_end;

`ifdef LED_SCHED_PRIO_EN
    assign sel_idx = prio_pick(req);
`else
    logic [IDX_W-1:0] last_q;

    // Round-robin pointer: remembers the last granted index, starts at the top.
    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst)                      last_q <= IDX_W'(NREQ - 1);
        else if (state == IDLE && |req)   last_q <= sel_idx;
    end

    assign sel_idx = rr_pick(req, last_q);
`endif

    assign sel_period = period_ms[sel_idx*PERIOD_W +: PERIOD_W];
    assign sel_blinks = blinks[sel_idx*COUNT_W +: COUNT_W];

    led_tick_gen #(.DIV(DIV)) u_tick (
        .sys_clk50m (sys_clk50m),
        .sys_rst    (sys_rst),
        .clear      (clear),
        .tick       (tick)
    );

    // State register.
    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state, phase end detection and LED decode.
    always_comb begin
        state_nxt = state;
        ph_last   = (state == GAP) ? GAP_LAST : period_q - PERIOD_W'(1);
        ph_end    = tick && (ph_cnt == ph_last);
        led       = 2'b00;
        case (state)
            IDLE: if (|req) state_nxt = ON;
            ON: begin
                // A zero blink count passes through ON for the grant cycle only.
                if (rem_q == '0) state_nxt = GAP;
                else begin
                    led = 2'b01;
                    if (ph_end) state_nxt = OFF;
                end
            end
            OFF: begin
                led = 2'b10;
                if (ph_end) state_nxt = (rem_q == COUNT_W'(1)) ? GAP : ON;
            end
            GAP:     if (ph_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Every phase entry (including OFF->ON) starts a fresh tick interval.
        clear = (state == IDLE) || (state_nxt != state);
    end

    // Service datapath: latch on grant, count ticks within a phase, count blinks down.
    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst) begin
            period_q <= '0;
            rem_q    <= '0;
            ph_cnt   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            done_q <= '0;
            if (state_nxt != state) ph_cnt <= '0;
            else if (tick)          ph_cnt <= ph_cnt + PERIOD_W'(1);
            if (state == IDLE && |req) begin
                period_q <= (sel_period == '0) ? PERIOD_W'(1) : sel_period;
                rem_q    <= sel_blinks;
                gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
            end
            if (state == OFF && ph_end) rem_q <= rem_q - COUNT_W'(1);
            if (state != GAP && state_nxt == GAP) begin
                gnt_q  <= '0;
                done_q <= gnt_q;
            end
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_blink_sched.sv
// tb_led_blink_sched: directed literal checks plus randomized traffic compared every
// cycle against a service-level model that expands each grant into its output timeline.
module tb_led_blink_sched;
    localparam int DIV  = 10;
    localparam int GAPT = 2;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic [1:0] led;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] period_ms;
    logic [31:0] blinks;
    logic [3:0]  gnt, done;
    logic        busy;
    logic [1:0]  led;

    int n_chk = 0;
    int n_err = 0;

    led_blink_sched #(.CLK_HZ(10), .TICK_HZ(1), .GAP_MS(GAPT)) dut (
        .sys_clk50m (clk),
        .sys_rst    (rst),
        .req        (req),
        .period_ms  (period_ms),
        .blinks     (blinks),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy),
        .led        (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    obs_t q[$];
    obs_t cur = '0;
    bit   prev_idle = 1'b1;
    int   ptr = 3;

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef LED_SCHED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
        return 0;
    endfunction

    // Expand one service into its cycle-by-cycle expected outputs.
    task automatic build(input int i);
        int p, b;
        logic [3:0] g;
        obs_t o;
        p = int'(period_ms[16*i +: 16]);
        if (p == 0) p = 1;
        b = int'(blinks[8*i +: 8]);
        g = 4'b0001 << i;
        if (b == 0) begin
            o = '{gnt: g, done: 4'b0, busy: 1'b1, led: 2'b00};
            q.push_back(o);
        end
        for (int k = 0; k < b; k++) begin
            for (int c = 0; c < p * DIV; c++) begin
                o = '{gnt: g, done: 4'b0, busy: 1'b1, led: 2'b01};
                q.push_back(o);
            end
            for (int c = 0; c < p * DIV; c++) begin
                o = '{gnt: g, done: 4'b0, busy: 1'b1, led: 2'b10};
                q.push_back(o);
            end
        end
        for (int c = 0; c < GAPT * DIV; c++) begin
            o = '{gnt: 4'b0, done: (c == 0) ? g : 4'b0, busy: 1'b1, led: 2'b00};
            q.push_back(o);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            cur = '0;
            prev_idle = 1'b1;
            ptr = 3;
        end else begin
            if (q.size() > 0) cur = q.pop_front();
            else if (prev_idle && req != 4'b0) begin
                ptr = pick(req, ptr);
                build(ptr);
                cur = q.pop_front();
            end else cur = '0;
            prev_idle = (cur.busy == 1'b0);
        end
    end

    // Per-cycle compare, away from the active edge.
    initial forever begin
        obs_t act, exp;
        @(negedge clk);
        #1;
        act = '{gnt: gnt, done: done, busy: busy, led: led};
        exp = rst ? obs_t'('0) : cur;
        chk("cycle", 32'(act), 32'(exp));
    end

    // ---------------- directed helpers ----------------
    task automatic cfg(input int i, input int p, input int b);
        period_ms[16*i +: 16] = 16'(p);
        blinks[8*i +: 8]      = 8'(b);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_led(input logic [1:0] v, output int n);
        n = 0;
        while (led === v && n < 2000) begin n++; step(); end
    endtask

    task automatic run_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin n++; step(); end
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        int t = 0;
        while (gnt === 4'b0 && t < 500) begin t++; step(); end
        if (t >= 500) chk("gnt_timeout", t, 0);
        g = gnt;
    endtask

    initial begin
        int n;
        logic [3:0] g;
        logic [3:0] exp_alt[3];
        rst = 1'b1; req = '0; period_ms = '0; blinks = '0;
        repeat (3) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_led", led, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("post_rst_busy", busy, 0);

        // Basic service: period 3, two blinks.
        cfg(0, 3, 2); req = 4'b0001;
        step(); chk("A_gnt", gnt, 4'b0001);
        req = 4'b0;
        run_led(2'b01, n); chk("A_on1", n, 30);
        run_led(2'b10, n); chk("A_off1", n, 30);
        run_led(2'b01, n); chk("A_on2", n, 30);
        run_led(2'b10, n); chk("A_off2", n, 30);
        chk("A_done", done, 4'b0001);
        run_busy(n); chk("A_gap", n, 20);

        // Arbitration with two requesters held.
        cfg(1, 1, 1); cfg(3, 1, 1); req = 4'b1010;
`ifdef LED_SCHED_PRIO_EN
        exp_alt = '{4'b0010, 4'b0010, 4'b0010};
`else
        exp_alt = '{4'b0010, 4'b1000, 4'b0010};
`endif
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g); chk("arb_gnt", g, exp_alt[k]);
            run_busy(n);
        end
        req = 4'b0;

        // Zero blinks.
        cfg(2, 5, 0); req = 4'b0100;
        step(); chk("Z_gnt", gnt, 4'b0100); chk("Z_led", led, 0);
        req = 4'b0;
        step(); chk("Z_gnt_off", gnt, 0); chk("Z_done", done, 4'b0100);
        run_busy(n); chk("Z_gap", n, 20);

        // Period zero behaves as one tick.
        cfg(0, 0, 1); req = 4'b0001;
        step(); chk("P0_gnt", gnt, 4'b0001);
        req = 4'b0;
        run_led(2'b01, n); chk("P0_on", n, 10);
        run_led(2'b10, n); chk("P0_off", n, 10);
        chk("P0_done", done, 4'b0001);
        run_busy(n);

        // Inputs changed mid-service are ignored.
        cfg(1, 2, 2); req = 4'b0010;
        step(); chk("M_gnt", gnt, 4'b0010);
        repeat (5) step();
        req = 4'b0; cfg(1, 7, 9);
        run_led(2'b01, n); chk("M_on1", n, 15);
        run_led(2'b10, n); chk("M_off1", n, 20);
        run_led(2'b01, n); chk("M_on2", n, 20);
        run_led(2'b10, n); chk("M_off2", n, 20);
        chk("M_done", done, 4'b0010);
        run_busy(n);

        // Reset in the middle of ON.
        cfg(0, 3, 2); req = 4'b0001;
        step(); chk("R_gnt", gnt, 4'b0001);
        req = 4'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1 chk("R_gnt0", gnt, 0); chk("R_led0", led, 0); chk("R_busy0", busy, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("R_nodone", done, 0);
        cfg(0, 1, 1); req = 4'b0001;
        step(); chk("R2_gnt", gnt, 4'b0001); chk("R2_led", led, 2'b01);
        req = 4'b0;
        run_led(2'b01, n); chk("R2_on", n, 10);
        run_led(2'b10, n); chk("R2_off", n, 10);
        chk("R2_done", done, 4'b0001);
        run_busy(n);

        // Randomized traffic checked by the model.
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0)
                cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        @(negedge clk); rst = 1'b0; req = '0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/led_blink_sched.md
LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, timebase tick rate in Hz. DIV = CLK_HZ/TICK_HZ, which SHALL be at least 2.
REQ-003 SHALL have parameter GAP_MS, default 100, idle gap in ticks enforced between served requests.
REQ-004 SHALL have ports, clock and reset first:
- sys_clk50m, input, 1: the single clock.
- sys_rst, input, 1: asynchronous, active-high reset.
- req, input, 4: per-requester blink request, level-sensitive.
- period_ms, input, 64: four 16-bit on/off phase lengths in ticks; requester i uses bits [16i+15:16i].
- blinks, input, 32: four 8-bit blink counts; requester i uses bits [8i+7:8i].
- gnt, output, 4: one-hot grant, high for the whole service of the granted requester.
- done, output, 4: one-cycle pulse on the requester whose service ended.
- busy, output, 1: high in any state other than IDLE.
- led, output, 2: driven LED pair.

Function
REQ-005 SHALL implement states IDLE, ON, OFF and GAP.
REQ-006 In IDLE with any req bit high, SHALL on the next edge select one requester (REQ-015) and do all of the following in the same cycle:
- latch that requester's period_ms and blinks;
- assert its gnt bit;
- enter ON.
REQ-007 Latched period value 0 SHALL be treated as 1.
REQ-008 Latched blinks value 0 SHALL skip ON and OFF: go directly to GAP, pulse done, leave led at 2'b00.
REQ-009 Each phase entry SHALL clear the tick prescaler. ON and OFF SHALL each last exactly period*DIV cycles.
REQ-010 At the end of OFF, SHALL decrement the remaining count. If the remaining count is nonzero, return to ON; if it is zero, enter GAP and pulse done[i] in the first GAP cycle.
REQ-011 gnt SHALL deassert on entry to GAP. GAP SHALL last GAP_MS*DIV cycles, then the block SHALL return to IDLE.
REQ-012 led SHALL be 2'b01 in ON, 2'b10 in OFF, and 2'b00 in IDLE and GAP.
REQ-013 After a grant, changes on req, period_ms and blinks SHALL be ignored until IDLE is re-entered. Deasserting req does not abort a service.
REQ-014 The tick prescaler SHALL count 0..DIV-1 and wrap. Phase counters SHALL be 16 bits and SHALL NOT overflow for period 65535.
REQ-015 Arbitration SHALL be round-robin: search starts at the index after the last granted requester, wrapping 3 to 0; the pointer starts at 3 after reset.
REQ-016 A req arriving in GAP SHALL be evaluated only once IDLE is reached.

Reset
REQ-017 sys_rst high SHALL immediately force all of the following, at any point including mid-phase:
- state IDLE;
- gnt=0, done=0, busy=0, led=2'b00;
- prescaler and counters at 0;
- round-robin pointer at 3.
REQ-018 No done pulse SHALL be generated for a service aborted by reset.

Configuration
REQ-019 Macro LED_SCHED_PRIO_EN SHALL select fixed priority, lowest index wins, and remove the round-robin pointer. Without the macro, round-robin per REQ-015 applies.

Structure
REQ-020 Package led_sched_pkg SHALL hold the state enum, NREQ=4, PERIOD_W=16 and COUNT_W=8.
REQ-021 The prescaler SHALL be sub-module led_tick_gen (inputs: clock, reset, clear; output: one-cycle tick).

Verification
Directed scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10) and GAP_MS=2.
REQ-022 req=4'b0001, period 3, blinks 2 -> gnt=0001 one cycle later, then:
- led 01 for 30 cycles, 10 for 30, 01 for 30, 10 for 30;
- done[0] pulse;
- busy low 20 cycles after done.
REQ-023 req=4'b1010 held -> grants alternate 0010, 1000, 0010. With LED_SCHED_PRIO_EN, grants are always 0010.
REQ-024 req[2] with blinks 0 -> gnt[2] for one cycle, done[2] the next cycle, led stays 00, busy 20 cycles.
REQ-025 period 0, blinks 1 -> ON 10 cycles, then OFF 10 cycles.
REQ-026 sys_rst pulsed at cycle 15 of ON -> same-cycle gnt=0, led=00, no done. A request after release is served from ON cleanly.
REQ-027 req dropped and period_ms changed mid-service -> timing and blink count unchanged, and done still pulses.
